// File: rtl/shift_seq.sv
// ---------------------------------------------------------------------------
// shift_seq -- multi-cycle 32-bit shifter / rotator with valid/ready handshakes
//
// Purpose:
//    Accepts one operand, a shift amount and an operation. The shift is then
//    carried out iteratively on a working register. The result is identical
//    to a single-cycle SLL / SRL / SRA / ROR of the operand.
//
// Ports:
//    i_clk    in   1   clock, rising edge
//    i_rst_n  in   1   asynchronous active-low reset
//    i_valid  in   1   request valid (sampled only in IDLE)
//    o_ready  out  1   high exactly in IDLE
//    i_Data   in  32   operand
//    i_sh     in   5   shift amount 0..31
//    i_mod    in   2   00 SLL, 01 SRL, 10 SRA, 11 ROR
//    i_flush  in   1   synchronous abort, returns to IDLE on the next edge
//    o_valid  out  1   high exactly in DONE
//    i_ready  in   1   consumer takes the result
//    o_Data   out 32   result (meaningful only while o_valid=1)
//
// Configuration:
//    SHIFT_FAST4_EN  When defined, SHIFT cycles with a remaining count >= 4
//                    step 4 bits at once. Otherwise every step is 1 bit.
//                    The final result is the same in both builds.
// ---------------------------------------------------------------------------
module shift_seq (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [31:0] i_Data,
   input  logic [4:0]  i_sh,
   input  logic [1:0]  i_mod,
   input  logic        i_flush,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [31:0] o_Data
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;

   logic [1:0]  state_q, state_d;
   logic [31:0] data_q,  data_d;
   logic [4:0]  cnt_q,   cnt_d;
   logic [1:0]  mod_q,   mod_d;

   // One-bit step of the working register
   function automatic logic [31:0] step1(input logic [31:0] d, input logic [1:0] m);
      logic [31:0] r;
      case (m)
         OP_SLL:  r = {d[30:0], 1'b0};
         OP_SRL:  r = {1'b0, d[31:1]};
         OP_SRA:  r = {d[31], d[31:1]};
         default: r = {d[0], d[31:1]};
      endcase
      return r;
   endfunction

`ifdef SHIFT_FAST4_EN
   // Four-bit step, equivalent to four consecutive step1 calls
   function automatic logic [31:0] step4(input logic [31:0] d, input logic [1:0] m);
      logic [31:0] r;
      case (m)
         OP_SLL:  r = {d[27:0], 4'b0000};
         OP_SRL:  r = {4'b0000, d[31:4]};
         OP_SRA:  r = {{4{d[31]}}, d[31:4]};
         default: r = {d[3:0], d[31:4]};
      endcase
      return r;
   endfunction
`endif

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      mod_d   = mod_q;

      if (i_flush) begin
         // Flush wins over everything, including a request arriving in IDLE
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (i_valid) begin
                  data_d  = i_Data;
                  mod_d   = i_mod;
                  cnt_d   = i_sh;
                  state_d = (i_sh != 5'd0) ? SHIFT : DONE;
               end
            end
            SHIFT: begin
               // cnt_q is at least 1 here, so the subtraction never wraps
`ifdef SHIFT_FAST4_EN
               if (cnt_q >= 5'd4) begin
                  data_d = step4(data_q, mod_q);
                  cnt_d  = cnt_q - 5'd4;
               end else begin
                  data_d = step1(data_q, mod_q);
                  cnt_d  = cnt_q - 5'd1;
               end
`else
               data_d = step1(data_q, mod_q);
               cnt_d  = cnt_q - 5'd1;
`endif
               if (cnt_d == 5'd0) begin
                  state_d = DONE;
               end
            end
            DONE: begin
               // A request is not accepted on the consume edge: the state
               // first returns to IDLE, so the earliest accept is next cycle
               if (i_ready) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         data_q  <= 32'd0;
         cnt_q   <= 5'd0;
         mod_q   <= OP_SLL;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         mod_q   <= mod_d;
      end
   end

   assign o_ready = (state_q == IDLE);
   assign o_valid = (state_q == DONE);
   assign o_Data  = data_q;

endmodule

// File: tb/tb_shift_seq.sv
module tb_shift_seq;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_valid;
   logic        o_ready;
   logic [31:0] i_Data;
   logic [4:0]  i_sh;
   logic [1:0]  i_mod;
   logic        i_flush;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_Data;

   int tests = 0;
   int fails = 0;

   shift_seq dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_Data  (i_Data),
      .i_sh    (i_sh),
      .i_mod   (i_mod),
      .i_flush (i_flush),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_Data  (o_Data)
   );

   always #5 i_clk = ~i_clk;

   // Single-cycle reference result, straight from the operator definitions
   function automatic logic [31:0] ref_shift(input logic [31:0] d, input int sh, input int m);
      logic [63:0] dd;
      case (m)
         0:       return d << sh;
         1:       return d >> sh;
         2:       return 32'($signed(d) >>> sh);
         default: begin
            dd = {d, d} >> sh;
            return dd[31:0];
         end
      endcase
   endfunction

   // Number of SHIFT cycles between accept and result
   function automatic int ref_steps(input int sh);
`ifdef SHIFT_FAST4_EN
      return sh / 4 + sh % 4;
`else
      return sh;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one request, verify latency, result, backpressure hold and the
   // consume handshake (with a competing request that must not be taken)
   task automatic do_req(input logic [31:0] d, input int sh, input int m,
                         input int hold, input string tag);
      int          lat;
      logic [31:0] exp;
      exp = ref_shift(d, sh, m);
      @(negedge i_clk);
      i_valid = 1'b1;
      i_Data  = d;
      i_sh    = 5'(sh);
      i_mod   = 2'(m);
      @(posedge i_clk); #1;
      // Scramble inputs: they must not influence the operation in flight
      i_valid = 1'b0;
      i_Data  = $urandom;
      i_sh    = 5'($urandom_range(31, 0));
      i_mod   = 2'($urandom_range(3, 0));
      lat = 0;
      while (o_valid !== 1'b1 && lat < 100) begin
         @(posedge i_clk); #1;
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'(ref_steps(sh)));
      check({tag, " data"}, o_Data, exp);
      check({tag, " ready_in_done"}, 32'(o_ready), 32'd0);
      for (int h = 0; h < hold; h++) begin
         @(posedge i_clk); #1;
         check({tag, " hold_valid"}, 32'(o_valid), 32'd1);
         check({tag, " hold_data"}, o_Data, exp);
      end
      @(negedge i_clk);
      i_ready = 1'b1;
      i_valid = 1'b1;
      i_sh    = 5'd7;
      @(posedge i_clk); #1;
      check({tag, " consumed_valid"}, 32'(o_valid), 32'd0);
      check({tag, " consumed_ready"}, 32'(o_ready), 32'd1);
      i_ready = 1'b0;
      i_valid = 1'b0;
   endtask

   initial begin
      int seen;
      i_rst_n = 1'b0;
      i_valid = 1'b0;
      i_Data  = 32'd0;
      i_sh    = 5'd0;
      i_mod   = 2'd0;
      i_flush = 1'b0;
      i_ready = 1'b0;
      #1;
      check("rst_ready", 32'(o_ready), 32'd1);
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_data", o_Data, 32'd0);
      #20;
      @(posedge i_clk); #2;
      i_rst_n = 1'b1;

      // Directed vectors
      do_req(32'h00000001, 31, 0, 0, "sll31");
      do_req(32'h80000000, 4, 2, 0, "sra4");
      do_req(32'hF0000000, 31, 1, 0, "srl31");
      do_req(32'h12345678, 8, 3, 0, "ror8");
      do_req(32'hDEADBEEF, 0, 0, 0, "sll0");
      do_req(32'hCAFEF00D, 0, 3, 0, "ror0");
      do_req(32'h80000001, 5, 2, 3, "backpressure");

      // Flush five cycles into a 20-bit SLL
      @(negedge i_clk);
      i_valid = 1'b1; i_Data = 32'h0000_0F0F; i_sh = 5'd20; i_mod = 2'd0;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      repeat (4) @(posedge i_clk);
      @(negedge i_clk);
      i_flush = 1'b1;
      @(posedge i_clk); #1;
      i_flush = 1'b0;
      check("flush_ready", 32'(o_ready), 32'd1);
      check("flush_valid", 32'(o_valid), 32'd0);
      seen = 0;
      repeat (25) begin
         @(posedge i_clk); #1;
         if (o_valid === 1'b1) seen++;
      end
      check("flush_no_result", 32'(seen), 32'd0);

      // Request presented together with flush is dropped
      @(negedge i_clk);
      i_valid = 1'b1; i_flush = 1'b1; i_sh = 5'd0; i_Data = 32'h1;
      @(posedge i_clk); #1;
      i_valid = 1'b0; i_flush = 1'b0;
      check("flush_req_ready", 32'(o_ready), 32'd1);
      check("flush_req_valid", 32'(o_valid), 32'd0);

      // Asynchronous reset in the middle of a SHIFT
      @(negedge i_clk);
      i_valid = 1'b1; i_Data = 32'h0000_00FF; i_sh = 5'd20; i_mod = 2'd0;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      repeat (3) @(posedge i_clk);
      #3;
      i_rst_n = 1'b0;
      #1;
      check("async_rst_valid", 32'(o_valid), 32'd0);
      check("async_rst_ready", 32'(o_ready), 32'd1);
      check("async_rst_data", o_Data, 32'd0);
      @(posedge i_clk); #2;
      i_rst_n = 1'b1;
      seen = 0;
      repeat (25) begin
         @(posedge i_clk); #1;
         if (o_valid === 1'b1) seen++;
      end
      check("after_rst_no_result", 32'(seen), 32'd0);
      do_req(32'hA5A5A5A5, 1, 3, 0, "ror1_after_rst");

      // Randomized sweep over every mode and shift amount
      for (int m = 0; m < 4; m++) begin
         for (int s = 0; s < 32; s++) begin
            do_req($urandom, s, m, $urandom_range(2, 0), $sformatf("rnd_m%0d_s%0d", m, s));
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/shift_seq.md
SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 i_clk  input  1  single clock; all state changes on rising edge.
REQ-002 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-003 i_valid  input  1  request valid.
REQ-004 o_ready  output  1  block can accept a request.
REQ-005 i_Data  input  32  operand.
REQ-006 i_sh  input  5  shift amount, 0..31.
REQ-007 i_mod  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
REQ-008 i_flush  input  1  synchronous abort of any operation in flight.
REQ-009 o_valid  output  1  result valid.
REQ-010 i_ready  input  1  consumer accepts result.
REQ-011 o_Data  output  32  shift result.

Function
REQ-012 States SHALL be IDLE, SHIFT and DONE; o_ready SHALL be 1 exactly in IDLE; o_valid SHALL be 1 exactly in DONE.
REQ-013 Accept: in IDLE with i_valid=1 and i_flush=0, the block SHALL latch i_Data, i_sh and i_mod, load a 5-bit remaining count with i_sh, and go to SHIFT if i_sh!=0 or to DONE if i_sh=0.
REQ-014 In SHIFT, each cycle SHALL perform one step of 1 bit on the working register and decrement the count by 1.
REQ-015 Step semantics: SLL shifts in 0 at bit 0; SRL shifts in 0 at bit 31; SRA replicates bit 31; ROR moves bit 0 to bit 31.
REQ-016 SHIFT SHALL go to DONE on the edge where the count reaches 0.
REQ-017 Latency: with accept on edge k and N steps, o_valid SHALL rise after edge k+N; with N=0 it SHALL rise after edge k.
REQ-018 N SHALL equal i_sh in the base build.
REQ-019 Final o_Data SHALL be bit-exact to a single-cycle shift: SLL i_Data<<sh, SRL logical >>sh, SRA arithmetic >>sh, ROR rotate-right by sh.
REQ-020 o_Data SHALL be driven from the working register, and its value outside DONE is don't-care.
REQ-021 In DONE, o_Data and o_valid SHALL hold stable until i_ready=1; on the edge where o_valid and i_ready are both 1, the state SHALL return to IDLE.
REQ-022 A new request SHALL NOT be accepted in the same cycle a result is consumed; the earliest accept is the following cycle.
REQ-023 i_valid, i_Data, i_sh and i_mod SHALL be ignored outside IDLE, and input changes during SHIFT or DONE SHALL NOT affect the result.
REQ-024 i_flush=1 in any state SHALL force IDLE on the next edge, discarding any pending result.
REQ-025 i_flush=1 with i_valid=1 in IDLE SHALL NOT accept the request.
REQ-026 i_sh=31 SHALL complete normally, and the count SHALL never wrap below 0.

Reset
REQ-027 When i_rst_n=0, the block SHALL immediately, without a clock edge, enter IDLE with o_ready=1, o_valid=0, o_Data=0 and count=0.
REQ-028 Reset asserted mid-SHIFT or mid-DONE SHALL abandon the operation, and no result SHALL be presented after release.
REQ-029 The first accept SHALL be possible on the first rising edge after i_rst_n deasserts.

Configuration
REQ-030 Macro SHIFT_FAST4_EN: when defined, each SHIFT cycle with count>=4 SHALL step 4 bits and subtract 4, and each SHIFT cycle with count<4 SHALL step 1 bit and subtract 1.
REQ-031 With SHIFT_FAST4_EN defined, N SHALL be floor(sh/4)+(sh mod 4).
REQ-032 Without SHIFT_FAST4_EN, only 1-bit steps SHALL exist, with N=sh.
REQ-033 The final o_Data SHALL be identical in both builds.

Verification
REQ-034 SLL, i_Data=0x00000001, sh=31 -> o_Data=0x80000000; o_valid rises 31 edges after accept, or 10 edges with SHIFT_FAST4_EN.
REQ-035 SRA, 0x80000000, sh=4 -> 0xF8000000; SRL, 0xF0000000, sh=31 -> 0x00000001; ROR, 0x12345678, sh=8 -> 0x78123456; any op with sh=0 -> operand unchanged, o_valid rises on the accept edge.
REQ-036 Backpressure: hold i_ready=0 for 3 cycles in DONE -> o_valid=1 and o_Data constant throughout; state is IDLE one edge after i_ready=1; o_ready=0 during the handshake cycle.
REQ-037 Assert i_flush 5 cycles into an SLL with sh=20 -> IDLE next edge, o_valid never asserts; a request applied with i_flush=1 is not accepted.
REQ-038 Drop i_rst_n asynchronously mid-SHIFT -> o_valid=0 and o_ready=1 without a clock edge; after release, ROR 0xA5A5A5A5 by 1 -> 0xD2D2D2D2.
REQ-039 Randomized back-to-back requests compared against a single-cycle reference model for all four modes and every sh in 0..31, in both macro builds.
